// File: rtl/rs_mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the memory arbiter and the memory block.
// The arbiter connects through the slave modport; the requesters and memory use master.
interface rs_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              gnt_cpu;
  logic              gnt_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output gnt_cpu, gnt_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  gnt_cpu, gnt_dma
  );
endinterface

// File: rtl/rs_mem_arbiter.sv
// Single-port memory arbiter between CPU and DMA: fixed 4-phase access
// (decide, issue, capture, acknowledge), CPU priority with a DMA starvation guard.
module rs_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic               CLK,
  input  logic               CLEAR,
  rs_mem_arbiter_if.slave    bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_dma_q, owner_dma_d;
  logic [3:0]        starve_q, starve_d;
  logic              load;
  logic              dma_win;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_WAIT_C) ? MAX_WAIT_C : v + 4'd1;
  endfunction

  assign dma_win = bus.dma_req && (!bus.cpu_req || starve_q == MAX_WAIT_C);

  always_comb begin
    state_d     = state_q;
    owner_dma_d = owner_dma_q;
    starve_d    = starve_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.dma_req) starve_d = 4'd0;
        if (dma_win) begin
          owner_dma_d = 1'b1;
          starve_d    = 4'd0;
          load        = 1'b1;
          state_d     = ISSUE;
        end else if (bus.cpu_req) begin
          owner_dma_d = 1'b0;
          if (bus.dma_req) starve_d = sat_inc(starve_q);
          load        = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE:   state_d = CAPT;
      CAPT:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decision edge: the winner's request fields are captured once and held
  // through the access, so later changes on the requester side cannot leak in.
  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q     <= IDLE;
      owner_dma_q <= 1'b0;
      starve_q    <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_dma_q <= owner_dma_d;
      starve_q    <= starve_d;
      if (load) begin
        we_q    <= dma_win ? bus.dma_we    : bus.cpu_we;
        addr_q  <= dma_win ? bus.dma_addr  : bus.cpu_addr;
        wdata_q <= dma_win ? bus.dma_wdata : bus.cpu_wdata;
      end
      // Capture stage: synchronous-read data arrives one cycle after the strobe.
      if (state_q == CAPT && !we_q) begin
        if (owner_dma_q) dma_rdata_q <= bus.mem_rdata;
        else             cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.gnt_cpu   = (state_q != IDLE) && !owner_dma_q;
  assign bus.gnt_dma   = (state_q != IDLE) &&  owner_dma_q;
  assign bus.cpu_ack   = (state_q == ACK)  && !owner_dma_q;
  assign bus.dma_ack   = (state_q == ACK)  &&  owner_dma_q;

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_rs_mem_arbiter.sv
// Bench for rs_mem_arbiter: directed scenarios plus random single accesses,
// checked against a reference memory and grant-order arithmetic.
module tb_rs_mem_arbiter;

  localparam int MAX_WAIT = 3;

  logic clk;
  logic clr;
  int   cyc;
  int   total;
  int   bad;

  rs_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  rs_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK   (clk),
    .CLEAR (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Behavioural memory with synchronous read.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          cyc;
  } iss_t;

  iss_t issues[$];
  int   cpu_acks;
  int   dma_acks;
  int   stray_we;
  int   both_gnt;

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1)
      issues.push_back('{{bus.gnt_dma, bus.gnt_cpu}, bus.mem_we, bus.mem_addr, bus.mem_wdata, cyc});
    if (bus.cpu_ack === 1'b1) cpu_acks++;
    if (bus.dma_ack === 1'b1) dma_acks++;
    if (bus.mem_we === 1'b1 && bus.mem_en !== 1'b1) stray_we++;
    if (bus.gnt_cpu === 1'b1 && bus.gnt_dma === 1'b1) both_gnt++;
  end

  // Reference model: expected memory contents and rdata registers.
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] cpu_exp;
  logic [7:0] dma_exp;

  function automatic logic [7:0] init_pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {26'd0, bus.mem_en, bus.mem_we, bus.gnt_cpu, bus.gnt_dma, bus.cpu_ack, bus.dma_ack}, 32'd0);
    chk({tag, "_data"}, {bus.cpu_rdata, bus.dma_rdata, bus.mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // One isolated access from one port, checked for latency, bus fields and rdata.
  task automatic do_acc(input bit dma, input bit we, input logic [15:0] addr,
                        input logic [7:0] wd, input string tag);
    int   base, ca0, da0, t0, ack_cyc;
    bit   got;
    iss_t r;
    base = issues.size();
    ca0  = cpu_acks;
    da0  = dma_acks;
    if (dma) begin
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    t0      = cyc;
    got     = 1'b0;
    ack_cyc = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if ((dma ? bus.dma_ack : bus.cpu_ack) === 1'b1) begin
        got     = 1'b1;
        ack_cyc = cyc;
      end
    end
    chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_ack_latency"}, ack_cyc - t0, 32'd3);
    if (we) ref_mem[addr] = wd;
    else if (dma) dma_exp = exp_rd(addr);
    else cpu_exp = exp_rd(addr);
    chk({tag, "_cpu_rdata"}, {24'd0, bus.cpu_rdata}, {24'd0, cpu_exp});
    chk({tag, "_dma_rdata"}, {24'd0, bus.dma_rdata}, {24'd0, dma_exp});
    chk({tag, "_issue_count"}, issues.size() - base, 32'd1);
    if (issues.size() > base) begin
      r = issues[base];
      chk({tag, "_issue_gnt"}, {30'd0, r.gnt}, dma ? 32'd2 : 32'd1);
      chk({tag, "_issue_addr_we"}, {15'd0, r.we, r.addr}, {15'd0, we, addr});
      if (we) chk({tag, "_issue_wdata"}, {24'd0, r.wd}, {24'd0, wd});
      chk({tag, "_issue_latency"}, r.cyc - t0, 32'd1);
    end
    step();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    chk({tag, "_ack_pulses"}, {cpu_acks - ca0, dma_acks - da0}, dma ? {32'd0, 32'd1} : {32'd1, 32'd0});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   base, ca0, da0, t0;
    iss_t r;
    logic [1:0] g_exp;

    total = 0; bad = 0; cyc = 0;
    cpu_acks = 0; dma_acks = 0; stray_we = 0; both_gnt = 0;
    cpu_exp = 8'h00; dma_exp = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = init_pat(16'(i));
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.mem_rdata = '0;
    clr = 1'b1;
    #1;
    chk_all_zero("reset_async");
    step();
    step();
    chk_all_zero("reset_held");
    clr = 1'b0;
    step();
    chk_all_zero("idle_after_reset");

    // Single CPU read.
    preload(16'h0010, 8'hA5);
    do_acc(1'b0, 1'b0, 16'h0010, 8'h00, "cpu_read");
    chk("cpu_read_value", {24'd0, bus.cpu_rdata}, 32'h0000_00A5);

    // DMA write, then CPU read-back.
    do_acc(1'b1, 1'b1, 16'h0200, 8'h3C, "dma_write");
    do_acc(1'b0, 1'b0, 16'h0200, 8'h00, "cpu_readback");
    chk("readback_value", {bus.dma_rdata, bus.cpu_rdata}, 32'h0000_003C);

    // Back-to-back CPU reads with address change in the cycle after ack.
    base = issues.size(); ca0 = cpu_acks;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
    t0 = cyc;
    step(); step(); step();
    chk("b2b_ack1", {31'd0, bus.cpu_ack}, 32'd1);
    cpu_exp = exp_rd(16'h0001);
    chk("b2b_rdata1", {24'd0, bus.cpu_rdata}, {24'd0, cpu_exp});
    step();
    bus.cpu_addr = 16'h0002;
    step(); step(); step();
    chk("b2b_ack2", {31'd0, bus.cpu_ack}, 32'd1);
    chk("b2b_ack2_latency", cyc - t0, 32'd7);
    cpu_exp = exp_rd(16'h0002);
    chk("b2b_rdata2", {24'd0, bus.cpu_rdata}, {24'd0, cpu_exp});
    step();
    bus.cpu_req = 1'b0;
    step(); step(); step(); step();
    chk("b2b_issue_count", issues.size() - base, 32'd2);
    chk("b2b_ack_count", cpu_acks - ca0, 32'd2);
    if (issues.size() >= base + 2) begin
      chk("b2b_addr1", {16'd0, issues[base].addr}, 32'h0001);
      chk("b2b_addr2", {16'd0, issues[base+1].addr}, 32'h0002);
      chk("b2b_spacing", issues[base+1].cyc - issues[base].cyc, 32'd4);
    end

    // DMA alone with request held high.
    base = issues.size(); da0 = dma_acks;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0400;
    for (int i = 0; i < 40 && issues.size() < base + 4; i++) step();
    bus.dma_req = 1'b0;
    step(); step(); step(); step(); step();
    dma_exp = exp_rd(16'h0400);
    chk("dma_alone_issue_count", issues.size() - base, 32'd4);
    chk("dma_alone_ack_count", dma_acks - da0, 32'd4);
    chk("dma_alone_rdata", {24'd0, bus.dma_rdata}, {24'd0, dma_exp});
    for (int k = 0; k < 4; k++) begin
      if (issues.size() > base + k) begin
        r = issues[base+k];
        chk($sformatf("dma_alone_gnt%0d", k), {30'd0, r.gnt}, 32'd2);
        if (k > 0) chk($sformatf("dma_alone_spacing%0d", k), r.cyc - issues[base+k-1].cyc, 32'd4);
      end
    end

    // Contention: both requests held high continuously.
    base = issues.size(); ca0 = cpu_acks; da0 = dma_acks;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0500;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0501;
    for (int i = 0; i < 80 && issues.size() < base + 8; i++) step();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    step(); step(); step(); step(); step();
    chk("cont_issue_count", issues.size() - base, 32'd8);
    chk("cont_ack_counts", {cpu_acks - ca0, dma_acks - da0}, {32'd6, 32'd2});
    for (int k = 0; k < 8; k++) begin
      if (issues.size() > base + k) begin
        g_exp = ((k % (MAX_WAIT + 1)) == MAX_WAIT) ? 2'b10 : 2'b01;
        chk($sformatf("cont_gnt%0d", k), {30'd0, issues[base+k].gnt}, {30'd0, g_exp});
        if (k > 0) chk($sformatf("cont_spacing%0d", k), issues[base+k].cyc - issues[base+k-1].cyc, 32'd4);
      end
    end
    cpu_exp = exp_rd(16'h0500);
    dma_exp = exp_rd(16'h0501);
    chk("cont_rdata", {16'd0, bus.cpu_rdata, bus.dma_rdata}, {16'd0, cpu_exp, dma_exp});

    // Reset asserted during CAPT of a CPU read.
    preload(16'h0020, 8'h5A);
    ca0 = cpu_acks;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    step(); step();
    chk("rst_capt_state", {30'd0, bus.gnt_cpu, bus.mem_en}, 32'd2);
    clr = 1'b1;
    #1;
    chk_all_zero("rst_capt_immediate");
    cpu_exp = 8'h00; dma_exp = 8'h00;
    step();
    chk_all_zero("rst_capt_held");
    chk("rst_capt_no_ack", cpu_acks - ca0, 32'd0);
    clr = 1'b0;
    t0 = cyc;
    step(); step(); step();
    chk("rst_retry_ack", {31'd0, bus.cpu_ack}, 32'd1);
    chk("rst_retry_latency", cyc - t0, 32'd3);
    cpu_exp = 8'h5A;
    chk("rst_retry_rdata", {24'd0, bus.cpu_rdata}, {24'd0, cpu_exp});
    step();
    bus.cpu_req = 1'b0;
    chk("rst_retry_ack_count", cpu_acks - ca0, 32'd1);
    step();

    // Random single accesses against the reference memory.
    for (int n = 0; n < 24; n++) begin
      do_acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'h0300 + 16'($urandom_range(0, 7)), 8'($urandom),
             $sformatf("rnd%0d", n));
    end

    chk("no_stray_mem_we", stray_we, 32'd0);
    chk("grant_onehot", both_gnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
